wb_timeout_guard: RTL

Wishbone (classic, single-outstanding) bus guard that sits directly downstream of the core's AXI4-Lite-to-Wishbone bridge and upstream of the Controller memory port. It forwards every transfer transparently. If the target never acknowledges, it terminates the cycle with a bus error on the bridge's error input, which is currently tied low. A guarded, aborted transfer can therefore never hang the core. It also keeps sticky timeout status for the host.

---
 rtl/wb_timeout_guard_pkg.sv | 21 ++
 rtl/wb_timeout_guard.sv | 138 +++++++++++++
 2 files changed

// File: rtl/wb_timeout_guard_pkg.sv
// -----------------------------------------------------------------------------
// wb_timeout_guard_pkg
// Shared definitions for the Wishbone timeout guard: FSM state encoding,
// default timeout/abort lengths and a saturating 8-bit increment helper.
// -----------------------------------------------------------------------------
package wb_timeout_guard_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_ABORT = 2'd2;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_ABORT_CYCLES   = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_timeout_guard.sv
// -----------------------------------------------------------------------------
// wb_timeout_guard
// Transparent Wishbone classic guard between the AXI4-Lite bridge and the
// Controller memory port. A transfer that is not acknowledged within
// TIMEOUT_CYCLES is terminated with up_err_o, the downstream cycle is then
// dropped for ABORT_CYCLES cycles, and sticky timeout status is kept.
//
// Ports:
//   clk_core, rst_core        clock, async active-high reset
//   up_cyc_i/up_stb_i         request from the bridge
//   up_ack_o/up_err_o/up_dat_o response to the bridge
//   dn_cyc_o/dn_stb_o         request to the Controller
//   dn_ack_i/dn_dat_i         response from the Controller
//   clear_i                   synchronous clear of status
//   timeout_o/timeout_cnt_o   sticky flag and saturating timeout count
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer pending; passthrough, first stb cycle of a transfer
// WAIT  | transfer outstanding, wait_cnt counts elapsed cycles
// ABORT | after a timeout; downstream cycle forced low, ack swallowed
// -----------------------------------------------------------------------------
module wb_timeout_guard
  import wb_timeout_guard_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned            ABORT_CYCLES   = DEF_ABORT_CYCLES,
  parameter logic [DATA_WIDTH-1:0]  ERR_DATA       = '0
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  up_cyc_i,
  input  logic                  up_stb_i,
  output logic                  up_ack_o,
  output logic                  up_err_o,
  output logic [DATA_WIDTH-1:0] up_dat_o,
  output logic                  dn_cyc_o,
  output logic                  dn_stb_o,
  input  logic                  dn_ack_i,
  input  logic [DATA_WIDTH-1:0] dn_dat_i,
  input  logic                  clear_i,
  output logic                  timeout_o,
  output logic [7:0]            timeout_cnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned ABT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ABT_W-1:0] ABT_LOAD = ABT_W'(ABORT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [ABT_W-1:0] r_abort_cnt;
  logic             r_timeout;
  logic [7:0]       r_timeout_cnt;
  logic             w_timeout_hit;

  assign timeout_o     = r_timeout;
  assign timeout_cnt_o = r_timeout_cnt;

  // Outputs are gated by rst_core so that nothing leaks through the
  // combinational passthrough while reset is held.
  always_comb begin
    dn_cyc_o      = 1'b0;
    dn_stb_o      = 1'b0;
    up_ack_o      = 1'b0;
    up_err_o      = 1'b0;
    up_dat_o      = '0;
    w_timeout_hit = 1'b0;
    if (!rst_core) begin
      if (r_state == ST_IDLE || r_state == ST_WAIT) begin
        dn_cyc_o = up_cyc_i;
        dn_stb_o = up_stb_i;
        up_ack_o = dn_ack_i & up_stb_i;
        up_dat_o = dn_dat_i;
        // Ack on the last allowed cycle wins over the error.
        if (r_state == ST_WAIT && up_cyc_i && !dn_ack_i && r_wait_cnt == CNT_LAST) begin
          up_err_o      = 1'b1;
          up_dat_o      = ERR_DATA;
          w_timeout_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_abort_cnt   <= '0;
      r_timeout     <= 1'b0;
      r_timeout_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (up_cyc_i && up_stb_i && !dn_ack_i) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (dn_ack_i || !up_cyc_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else if (w_timeout_hit) begin
            r_state     <= ST_ABORT;
            r_wait_cnt  <= '0;
            r_abort_cnt <= ABT_LOAD;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_ABORT: begin
          if (r_abort_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_abort_cnt <= r_abort_cnt - ABT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase

      // A timeout in the same cycle as clear_i restarts the count at one.
      if (w_timeout_hit) begin
        r_timeout     <= 1'b1;
        r_timeout_cnt <= clear_i ? 8'd1 : sat_inc8(r_timeout_cnt);
      end else if (clear_i) begin
        r_timeout     <= 1'b0;
        r_timeout_cnt <= 8'd0;
      end
    end
  end

endmodule
